// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-PC sequencer with one-instruction branch delay slot,
//            link-address generation, halt-on-target and misaligned-JR fault.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        condition_met,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_readdata,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DELAY = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] target;
  logic        target_bad;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] next_target;
  logic        next_bad;

  assign pc_plus4      = pc + 32'd4;
  assign link_addr     = pc + 32'd8;
  assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign redirect      = jump_reg | jump | condition_met;

  // Priority: register jump, then absolute jump, then conditional branch.
  always_comb begin
    next_target = branch_target;
    next_bad    = 1'b0;
    if (jump_reg) begin
      next_target = rs_readdata;
      next_bad    = (rs_readdata[1:0] != 2'b00);
    end else if (jump) begin
      next_target = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      pc            <= RESET_VECTOR;
      target        <= 32'd0;
      target_bad    <= 1'b0;
      in_delay_slot <= 1'b0;
      active        <= 1'b1;
      fault         <= 1'b0;
    end else if (advance) begin
      case (state)
        S_RUN: begin
          pc <= pc_plus4;
          if (redirect) begin
            target        <= next_target;
            target_bad    <= next_bad;
            state         <= S_DELAY;
            in_delay_slot <= 1'b1;
          end
        end
        // Redirect inputs are not sampled here: a branch in the slot is dropped.
        S_DELAY: begin
          in_delay_slot <= 1'b0;
          target_bad    <= 1'b0;
          if (target_bad) begin
            state  <= S_FAULT;
            active <= 1'b0;
            fault  <= 1'b1;
          end else if (target == HALT_ADDR) begin
            state  <= S_HALT;
            pc     <= HALT_ADDR;
            active <= 1'b0;
          end else begin
            state <= S_RUN;
            pc    <= target;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// Testbench for pc_sequencer: directed scenarios plus randomized run against
// a behavioural model of the fetch sequence.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, advance, condition_met, jump, jump_reg;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] rs_readdata;
  logic [31:0] pc, link_addr;
  logic        in_delay_slot, active, fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RV = 32'hBFC00000;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .advance(advance), .condition_met(condition_met),
    .jump(jump), .jump_reg(jump_reg), .imm(imm), .instr_index(instr_index),
    .rs_readdata(rs_readdata), .pc(pc), .link_addr(link_addr),
    .in_delay_slot(in_delay_slot), .active(active), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic a, input logic c, input logic j, input logic jr,
                       input logic [15:0] im, input logic [25:0] ix, input logic [31:0] rs);
    advance = a; condition_met = c; jump = j; jump_reg = jr;
    imm = im; instr_index = ix; rs_readdata = rs;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RV); end
    checks++; if (active !== 1'b1 || fault !== 1'b0 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL reset_flags got act=%b flt=%b ds=%b want 1 0 0", active, fault, in_delay_slot); end
    checks++; if (link_addr !== RV + 32'd8) begin errors++; $display("FAIL reset_link got %h want %h", link_addr, RV + 32'd8); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = RV + 32'(i * 4);
      checks++; if (pc !== exp || link_addr !== exp + 32'd8 || active !== 1'b1) begin
        errors++; $display("FAIL seq_step%0d got pc=%h link=%h act=%b want %h %h 1", i, pc, link_addr, active, exp, exp + 32'd8); end
    end
    // advance low: redirect inputs are don't-care
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom), 26'($urandom), $urandom);
    checks++; if (pc !== RV + 32'd12 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL seq_hold got pc=%h ds=%b want %h 0", pc, in_delay_slot, RV + 32'd12); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    checks++; if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL branch_slot got pc=%h ds=%b want bfc00014 1", pc, in_delay_slot); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 26'h0, 32'h0);
    checks++; if (pc !== 32'hBFC00004 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL branch_target got pc=%h ds=%b want bfc00004 0", pc, in_delay_slot); end
    step();
    checks++; if (pc !== 32'hBFC00008) begin errors++; $display("FAIL branch_slot_ignored got %h want bfc00008", pc); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (8) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
    checks++; if (pc !== 32'hBFC00024 || in_delay_slot !== 1'b1 || active !== 1'b1) begin
      errors++; $display("FAIL halt_slot got pc=%h ds=%b act=%b want bfc00024 1 1", pc, in_delay_slot, active); end
    step();
    checks++; if (pc !== 32'h0 || active !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL halt_enter got pc=%h act=%b flt=%b want 0 0 0", pc, active, fault); end
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 26'h1234, 32'h100);
    checks++; if (pc !== 32'h0 || active !== 1'b0 || link_addr !== 32'h8) begin
      errors++; $display("FAIL halt_hold got pc=%h act=%b link=%h want 0 0 8", pc, active, link_addr); end
  endtask

  task automatic test_jump();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100, 32'h0);
    checks++; if (pc !== 32'hBFC00004 || in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL jump_slot got pc=%h ds=%b want bfc00004 1", pc, in_delay_slot); end
    step();
    checks++; if (pc !== 32'hB0000400) begin errors++; $display("FAIL jump_target got %h want b0000400", pc); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h0000200, 32'h12345678);
    step();
    checks++; if (pc !== 32'h12345678) begin errors++; $display("FAIL jump_prio got %h want 12345678", pc); end
  endtask

  task automatic test_fault();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h00000402);
    checks++; if (pc !== 32'hBFC00004 || fault !== 1'b0 || active !== 1'b1) begin
      errors++; $display("FAIL fault_slot got pc=%h flt=%b act=%b want bfc00004 0 1", pc, fault, active); end
    step();
    checks++; if (pc !== 32'hBFC00004 || fault !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL fault_enter got pc=%h flt=%b act=%b want bfc00004 1 0", pc, fault, active); end
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 26'h0, 32'h00000400);
    checks++; if (pc !== 32'hBFC00004 || fault !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL fault_hold got pc=%h flt=%b act=%b want bfc00004 1 0", pc, fault, active); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 26'h0, 32'h0);
    do_reset();
    checks++; if (pc !== RV || in_delay_slot !== 1'b0 || active !== 1'b1) begin
      errors++; $display("FAIL rst_delay got pc=%h ds=%b act=%b want %h 0 1", pc, in_delay_slot, active, RV); end
    step();
    checks++; if (pc !== RV + 32'd4) begin errors++; $display("FAIL rst_discard got %h want %h", pc, RV + 32'd4); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
    step();
    do_reset();
    checks++; if (pc !== RV || active !== 1'b1 || fault !== 1'b0 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL rst_halt got pc=%h act=%b flt=%b ds=%b want %h 1 0 0", pc, active, fault, in_delay_slot, RV); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'hFFFFFFF8);
    step();
    step();
    checks++; if (pc !== 32'hFFFFFFFC || link_addr !== 32'h4) begin
      errors++; $display("FAIL wrap_link got pc=%h link=%h want fffffffc 00000004", pc, link_addr); end
    step();
    checks++; if (pc !== 32'h0 || active !== 1'b1) begin
      errors++; $display("FAIL wrap_nohalt got pc=%h act=%b want 0 1", pc, active); end
  endtask

  // Behavioural reference: a queue holds the one redirect awaiting its slot.
  task automatic test_random();
    logic [31:0] m_pc;
    bit          m_halted, m_faulted;
    logic [31:0] pend_q[$];
    bit          pend_bad;
    logic        a, c, j, jr, rst;
    logic [15:0] im;
    logic [25:0] ix;
    logic [31:0] rs, tgt;
    int          stuck;
    do_reset();
    m_pc = RV; m_halted = 0; m_faulted = 0; pend_bad = 0; stuck = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0) || (stuck > 3);
      a   = ($urandom_range(0, 3) != 0);
      jr  = ($urandom_range(0, 6) == 0);
      j   = ($urandom_range(0, 4) == 0);
      c   = ($urandom_range(0, 3) == 0);
      im  = 16'($urandom);
      ix  = 26'($urandom);
      case ($urandom_range(0, 5))
        0:       rs = 32'h0;
        1:       rs = $urandom;
        default: rs = $urandom & 32'hFFFFFFFC;
      endcase
      if (rst) begin
        m_pc = RV; m_halted = 0; m_faulted = 0; pend_q.delete(); pend_bad = 0; stuck = 0;
      end else if (a && !m_halted && !m_faulted) begin
        if (pend_q.size() != 0) begin
          tgt = pend_q.pop_front();
          if (pend_bad) m_faulted = 1;
          else if (tgt == 32'h0) begin m_halted = 1; m_pc = 32'h0; end
          else m_pc = tgt;
          pend_bad = 0;
        end else begin
          if (jr) begin tgt = rs; pend_bad = (rs % 4) != 0; end
          else if (j) tgt = ((m_pc + 32'd4) & 32'hF0000000) | ({6'd0, ix} * 4);
          else tgt = m_pc + 32'd4 + 32'(int'($signed(im)) * 4);
          if (jr || j || c) pend_q.push_back(tgt);
          m_pc = m_pc + 32'd4;
        end
      end
      if (m_halted || m_faulted) stuck++;
      reset = rst;
      drive(a, c, j, jr, im, ix, rs);
      reset = 1'b0;
      checks++; if (pc !== m_pc || link_addr !== m_pc + 32'd8) begin
        errors++; $display("FAIL rand%0d_pc got pc=%h link=%h want %h %h", n, pc, link_addr, m_pc, m_pc + 32'd8); end
      checks++; if (active !== !(m_halted || m_faulted) || fault !== m_faulted) begin
        errors++; $display("FAIL rand%0d_status got act=%b flt=%b want %b %b", n, active, fault, !(m_halted || m_faulted), m_faulted); end
      if (!m_halted && !m_faulted) begin
        checks++; if (in_delay_slot !== (pend_q.size() != 0)) begin
          errors++; $display("FAIL rand%0d_ds got %b want %b", n, in_delay_slot, pend_q.size() != 0); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    advance = 1'b0; condition_met = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    imm = 16'h0; instr_index = 26'h0; rs_readdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_jump();
    test_fault();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
